// File: rtl/bkm_shift_add_iter.sv
// BKM E-mode shift-and-add iterator: X(n+1) = X(n) + d(n)*(X(n) >>> n).
// Drives an external combinational shifter and folds its output back into X.
module bkm_shift_add_iter #(
    parameter int   W       = 8,
    parameter int   LOG2W   = 3,
    parameter int   ITERS   = 4,
    parameter logic SH_DIR  = 1'b1,
    parameter logic SH_TYPE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     x_in,
    input  logic             d_valid,
    input  logic [1:0]       d,
    output logic             d_ready,
    output logic             sh_dir,
    output logic             sh_op,
    output logic             sh_shift_t,
    output logic [LOG2W-1:0] sh_sel,
    output logic [W-1:0]     sh_in,
    input  logic [W-1:0]     sh_out,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     x_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [LOG2W-1:0] N_LAST = LOG2W'(ITERS);
    localparam logic [LOG2W-1:0] N_ONE  = LOG2W'(1);

    state_t           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [LOG2W-1:0] n_q, n_d;
    logic             ovf_q, ovf_d;

    logic [W:0] x_ext;
    logic [W:0] s_ext;
    logic [W:0] sum;

    assign x_ext = {x_q[W-1], x_q};
    assign s_ext = {sh_out[W-1], sh_out};

    // Sum is one bit wider than X so a wrap shows up as sum[W] != sum[W-1]
    always_comb begin
        case (d)
            2'b01:   sum = x_ext + s_ext;
            2'b11:   sum = x_ext - s_ext;
            default: sum = x_ext;
        endcase
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x_in;
                    n_d     = N_ONE;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (d_valid) begin
                    x_d = sum[W-1:0];
                    if (sum[W] != sum[W-1]) begin
                        ovf_d = 1'b1;
                    end
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        n_d = n_q + N_ONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d_ready    = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign sh_dir     = SH_DIR;
    assign sh_op      = 1'b0;
    assign sh_shift_t = SH_TYPE;
    assign sh_sel     = n_q;
    assign sh_in      = x_q;
    assign x_out      = x_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_bkm_shift_add_iter.sv
// Directed bench for bkm_shift_add_iter; acts as the arithmetic right shifter
// and scoreboards final results against the done pulse.
module tb_bkm_shift_add_iter;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x_in;
    logic       d_valid;
    logic [1:0] d;
    logic       d_ready;
    logic       sh_dir;
    logic       sh_op;
    logic       sh_shift_t;
    logic [2:0] sh_sel;
    logic [7:0] sh_in;
    logic [7:0] sh_out;
    logic       busy;
    logic       done;
    logic [7:0] x_out;
    logic       ovf;

    typedef struct packed {
        logic [7:0] x;
        logic       ovf;
    } res_t;

    res_t exp_q[$];
    int   total;
    int   bad;
    int   done_cnt;

    bkm_shift_add_iter #(
        .W(8), .LOG2W(3), .ITERS(4), .SH_DIR(1'b1), .SH_TYPE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .d_valid(d_valid), .d(d), .d_ready(d_ready),
        .sh_dir(sh_dir), .sh_op(sh_op), .sh_shift_t(sh_shift_t),
        .sh_sel(sh_sel), .sh_in(sh_in), .sh_out(sh_out),
        .busy(busy), .done(done), .x_out(x_out), .ovf(ovf)
    );

    assign sh_out = $signed(sh_in) >>> sh_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        res_t r;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                r = exp_q.pop_front();
                chk("sb_x_out", 32'(x_out), 32'(r.x));
                chk("sb_ovf", 32'(ovf), 32'(r.ovf));
            end
        end
    endtask

    task automatic run(input string tag, input logic [7:0] x0,
                       input logic [0:3][1:0] dg,
                       input logic [0:3][7:0] xs,
                       input logic [0:3] ov,
                       input int stall, input bit ign);
        int dc0;
        dc0 = done_cnt;
        start = 1'b1;
        x_in  = x0;
        exp_q.push_back('{x: xs[3], ovf: ov[3]});
        tick();
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ovf_clr"}, 32'(ovf), 32'd0);
        chk({tag, "_x_load"}, 32'(x_out), 32'(x0));
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < stall; s++) begin
                d_valid = 1'b0;
                d       = 2'b01;
                tick();
                chk({tag, "_stall_x"}, 32'(x_out),
                    (i == 0) ? 32'(x0) : 32'(xs[i-1]));
                chk({tag, "_stall_rdy"}, 32'(d_ready), 32'd1);
                chk({tag, "_stall_sel"}, 32'(sh_sel), 32'(i + 1));
            end
            d_valid = 1'b1;
            d       = dg[i];
            if (ign && i == 0) begin
                start = 1'b1;
                x_in  = 8'd99;
            end
            #1;
            chk({tag, "_sel"}, 32'(sh_sel), 32'(i + 1));
            tick();
            start   = 1'b0;
            d_valid = 1'b0;
            chk({tag, "_x_step"}, 32'(x_out), 32'(xs[i]));
            chk({tag, "_ovf_step"}, 32'(ovf), 32'(ov[i]));
        end
        chk({tag, "_done_pulse"}, 32'(done), 32'd1);
        chk({tag, "_done_rdy"}, 32'(d_ready), 32'd0);
        if (ign) begin
            start = 1'b1;
            x_in  = 8'd99;
        end
        tick();
        start = 1'b0;
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_x"}, 32'(x_out), 32'(xs[3]));
        chk({tag, "_done_cnt"}, 32'(done_cnt - dc0), 32'd1);
    endtask

    logic [0:3][1:0] dg;
    logic [0:3][7:0] xs;
    logic [0:3]      ov;

    initial begin
        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        start    = 1'b0;
        x_in     = 8'd0;
        d_valid  = 1'b0;
        d        = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdy", 32'(d_ready), 32'd0);
        chk("rst_sel", 32'(sh_sel), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("const_dir", 32'(sh_dir), 32'd1);
        chk("const_op", 32'(sh_op), 32'd0);
        chk("const_type", 32'(sh_shift_t), 32'd1);
        tick();

        dg = {2'b01, 2'b01, 2'b01, 2'b01};
        xs = {8'd48, 8'd60, 8'd67, 8'd71};
        ov = 4'b0000;
        run("t1", 8'd32, dg, xs, ov, 0, 1'b0);

        dg = {2'b11, 2'b11, 2'b11, 2'b11};
        xs = {8'd32, 8'd24, 8'd21, 8'd20};
        run("t2", 8'd64, dg, xs, ov, 0, 1'b0);

        dg = {2'b01, 2'b01, 2'b01, 2'b01};
        xs = {8'hA0, 8'h88, 8'h79, 8'h80};
        ov = 4'b0011;
        run("t3", 8'hC0, dg, xs, ov, 0, 1'b0);

        xs = {8'd48, 8'd60, 8'd67, 8'd71};
        ov = 4'b0000;
        run("t4", 8'd32, dg, xs, ov, 3, 1'b0);

        dg = {2'b00, 2'b10, 2'b11, 2'b01};
        xs = {8'd32, 8'd32, 8'd28, 8'd29};
        run("t5", 8'd32, dg, xs, ov, 0, 1'b1);

        start = 1'b1;
        x_in  = 8'd32;
        exp_q.push_back('{x: 8'd71, ovf: 1'b0});
        tick();
        start   = 1'b0;
        d_valid = 1'b1;
        d       = 2'b01;
        tick();
        tick();
        d_valid = 1'b0;
        chk("t6_mid_x", 32'(x_out), 32'd60);
        rst = 1'b1;
        void'(exp_q.pop_back());
        tick();
        rst = 1'b0;
        chk("t6_rst_x", 32'(x_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_rdy", 32'(d_ready), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        tick();
        chk("t6_no_done", 32'(done), 32'd0);
        dg = {2'b01, 2'b01, 2'b01, 2'b01};
        xs = {8'd48, 8'd60, 8'd67, 8'd71};
        run("t6", 8'd32, dg, xs, ov, 0, 1'b0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("done_total", 32'(done_cnt), 32'd6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bkm_shift_add_iter.md
Name: bkm_shift_add_iter

Overview:
- Iterative shift-and-add datapath for the BKM E-mode recurrence X(n+1) = X(n) + d(n)*(X(n) >>> n), for n = 1..ITERS.
- Sits directly upstream of barrel_shifter_csd and consumes its output. It drives the shifter with the current X and shift amount n, then adds the shifted value back into X.
- Digits d(n) arrive from the digit-selection stage over a valid/ready handshake.
- Result and overflow are held for the downstream normaliser.

Parameters:
- W, 8, datapath width (two's complement).
- LOG2W, 3, width of shift select; must satisfy 2^LOG2W >= W.
- ITERS, 4, number of iterations; legal range 1..W-1.
- SH_DIR, 1'b1, constant driven on sh_dir to select a right shift.
- SH_TYPE, 1'b1, constant driven on sh_shift_t to select an arithmetic (sign-filling) shift.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  load x_in and begin; accepted only in IDLE
- x_in  in  W  signed initial value
- d_valid  in  1  digit valid
- d  in  2  digit: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0, 2'b10 = illegal (treated as 0)
- d_ready  out  1  high in RUN only
- sh_dir  out  1  constant SH_DIR
- sh_op  out  1  constant 1'b0 (plain shift, no operand negation)
- sh_shift_t  out  1  constant SH_TYPE
- sh_sel  out  LOG2W  current iteration index n
- sh_in  out  W  current X register
- sh_out  in  W  X >>> n, returned combinationally by the shifter
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result valid
- x_out  out  W  X register (always driven)
- ovf  out  1  sticky overflow for the current run

Behaviour:

Reset (rst=1 at a clk edge):
- state = IDLE, X = 0, n = 0, ovf = 0.
- Outputs: done = 0, d_ready = 0, busy = 0, sh_sel = 0, x_out = 0.
- Reset overrides every other input on the same edge, including mid-run; a partial run is discarded.

State machine: IDLE -> RUN -> DONE -> IDLE.

IDLE:
- On start=1: X <= x_in, n <= 1, ovf <= 0, go to RUN.
- Otherwise hold. X and ovf keep the last result.

RUN:
- d_ready = 1.
- On an edge with d_valid=1 (digit accepted):
  - Compute sum = X + dv*sh_out, where dv is -1, 0 or +1, evaluated in W+1 bits.
  - X <= sum[W-1:0] (wrap-around).
  - If sum is outside [-2^(W-1), 2^(W-1)-1], set ovf <= 1 (sticky until the next start or reset).
  - If n == ITERS, go to DONE and leave n unchanged. Otherwise n <= n+1.
- d_valid=0: stall. X, n and ovf hold.
- start in RUN is ignored.
- d=2'b10 behaves as d=0: X unchanged, n still advances.

DONE:
- done = 1 for exactly one cycle, then go to IDLE unconditionally.
- start in DONE is ignored; the source must retry in IDLE.

Timing and datapath rules:
- Latency with d_valid held high: start sampled at edge E0, digits consumed at E1..E_ITERS. done is high between E_ITERS and E_ITERS+1. Minimum run is ITERS+2 cycles from start to the next accepted start.
- The shifter path is purely combinational from registers X and n, with no loop back into the shifter's inputs.
- sh_sel = n in RUN, and n otherwise (0 after reset).

Test Plan (W=8, ITERS=4):
1. x_in=32, d=+1 four times, d_valid held high -> X sequence 48, 60, 67, 71. done pulses exactly once, 5 cycles after the start cycle; x_out=71, ovf=0.
2. x_in=64, d=-1 four times -> X sequence 32, 24, 21, 20. x_out=20, ovf=0. sh_sel observed as 1, 2, 3, 4 on the accepting edges.
3. x_in=-64, d=+1 four times -> -96, -120, then wrap to 121 with ovf=1, then -128. Final x_out=-128 (0x80), ovf stays 1. Next start clears ovf.
4. x_in=32, digits +1,+1,+1,+1 with d_valid low for 3 cycles between each digit -> same result 71. X and n hold during stalls; d_ready stays 1 throughout RUN.
5. x_in=32, digits 0, 2'b10, -1, +1 -> 32, 32, 28 (32-4), 29 (28+1). Assert start during RUN and during DONE -> both ignored, no restart.
6. rst asserted after the second digit of a run -> next edge: state IDLE, x_out=0, busy=0, d_ready=0, no done pulse. A following start with x_in=32 and +1 digits yields 71.
